// File: rtl/tmpl_xcorr_pkg.sv
// tmpl_xcorr_pkg: shared types, action bit positions and size helpers for the template correlator.
package tmpl_xcorr_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;

    localparam int ACT_FLIP = 0;
    localparam int ACT_NEG  = 1;

    function automatic int out_width(input int pix_w);
        return 2 * pix_w + 4;
    endfunction

    function automatic int decode_size(input logic [1:0] code, input int max_size);
        int s;
        s = code == 2'd0 ? 4 : code == 2'd1 ? 8 : 16;
        return s > max_size ? max_size : s;
    endfunction

endpackage

// File: rtl/xcorr_mac.sv
// xcorr_mac: nine-step sequential multiply-accumulate, one product per cycle.
module xcorr_mac #(
    parameter int PIX_W = 8,
    parameter int OUT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PIX_W-1:0] a,
    input  logic [PIX_W-1:0] b,
    output logic             busy,
    output logic [3:0]       tap,
    output logic             done,
    output logic [OUT_W-1:0] result
);

    logic [OUT_W-1:0]   acc;
    logic [2*PIX_W-1:0] prod;

    assign prod   = a * b;
    assign result = acc + OUT_W'(prod);
    assign done   = busy && tap == 4'd8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            tap  <= '0;
            acc  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            tap  <= '0;
            acc  <= '0;
        end else if (busy) begin
            acc  <= result;
            tap  <= done ? 4'd0 : tap + 4'd1;
            busy <= !done;
        end
    end

endmodule

// File: rtl/tmpl_xcorr.sv
// tmpl_xcorr: zero-padded 3x3 template cross-correlation over a loaded image,
// with optional flip/negate, results shifted out bit-serially MSB first.
module tmpl_xcorr
    import tmpl_xcorr_pkg::*;
#(
    parameter int PIX_W    = 8,
    parameter int MAX_SIZE = 16,
    parameter int OUT_W    = out_width(PIX_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_valid2,
    input  logic [PIX_W-1:0] image,
    input  logic [PIX_W-1:0] template,
    input  logic [1:0]       image_size,
    input  logic [1:0]       action,
    output logic             out_valid,
    output logic             out_value
);

    localparam int AW = $clog2(MAX_SIZE);
    localparam int BW = $clog2(OUT_W);

    state_t           state;
    logic [PIX_W-1:0] mem [MAX_SIZE*MAX_SIZE];
    logic [PIX_W-1:0] tmpl [9];
    logic [AW:0]      n, rr, cc, col;
    logic [AW-1:0]    pr, pc;
    logic [3:0]       tcnt, tidx, tap;
    logic             flip, neg, loaded, loading, start, busy, done, inb, step;
    logic [BW-1:0]    bitcnt;
    logic [2*AW:0]    ow, last_ow;
    logic [OUT_W-1:0] shreg, result;
    logic [1:0]       ti, tj;
    logic [PIX_W-1:0] pix, opnd;
    logic [2*AW-1:0]  waddr;

    assign loading = in_valid && (state == IDLE || state == LOAD);
    assign waddr   = state == IDLE ? '0 : {pr, pc};
    assign tidx    = state == IDLE ? 4'd0 : tcnt;

    always_ff @(posedge clk) begin
        if (loading) mem[waddr] <= image;
        if (loading && tidx < 4'd9) tmpl[tidx] <= template;
    end

    // Neighbour coordinates are offset by +1 so row/col 0 and N+1 mark the padding ring.
    assign ti   = tap >= 4'd6 ? 2'd2 : tap >= 4'd3 ? 2'd1 : 2'd0;
    assign tj   = 2'(tap - 4'd3 * 4'(ti));
    assign rr   = (AW+1)'(pr) + (AW+1)'(ti);
    assign cc   = (AW+1)'(pc) + (AW+1)'(tj);
    assign inb  = rr != '0 && rr <= n && cc != '0 && cc <= n;
    assign col  = flip ? n - cc : cc - 1'b1;
    assign pix  = mem[{AW'(rr - 1'b1), AW'(col)}];
    assign opnd = !inb ? '0 : neg ? ~pix : pix;

    assign last_ow = (2*AW+1)'(n) * (2*AW+1)'(n) - (2*AW+1)'(1);
    // Launching ten bits before a word ends lands the next result exactly on its first bit.
    assign start = (state == CALC && !busy) ||
                   (state == OUT && bitcnt == BW'(OUT_W - 10) && ow != last_ow);
    assign step  = (state == LOAD && in_valid) || done;

    xcorr_mac #(.PIX_W(PIX_W), .OUT_W(OUT_W)) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (opnd),
        .b      (tmpl[tap]),
        .busy   (busy),
        .tap    (tap),
        .done   (done),
        .result (result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            n         <= '0;
            pr        <= '0;
            pc        <= '0;
            tcnt      <= '0;
            flip      <= 1'b0;
            neg       <= 1'b0;
            loaded    <= 1'b0;
            bitcnt    <= '0;
            ow        <= '0;
            shreg     <= '0;
            out_valid <= 1'b0;
            out_value <= 1'b0;
        end else begin
            if (step) begin
                pc <= pc == AW'(n - 1'b1) ? '0 : pc + 1'b1;
                if (pc == AW'(n - 1'b1)) pr <= pr + 1'b1;
            end
            case (state)
                IDLE: if (in_valid) begin
                    state  <= LOAD;
                    loaded <= 1'b0;
                    n      <= (AW+1)'(decode_size(image_size, MAX_SIZE));
                    pr     <= '0;
                    pc     <= AW'(1);
                    tcnt   <= 4'd1;
                end else if (in_valid2 && loaded) begin
                    state <= CALC;
                    flip  <= action[ACT_FLIP];
                    neg   <= action[ACT_NEG];
                    pr    <= '0;
                    pc    <= '0;
                end
                LOAD: if (in_valid) begin
                    if (tcnt < 4'd9) tcnt <= tcnt + 4'd1;
                end else begin
                    state  <= IDLE;
                    loaded <= 1'b1;
                    pr     <= '0;
                    pc     <= '0;
                end
                CALC: if (done) begin
                    state     <= OUT;
                    out_valid <= 1'b1;
                    out_value <= result[OUT_W-1];
                    shreg     <= result;
                    bitcnt    <= '0;
                    ow        <= '0;
                end
                OUT: if (done) begin
                    out_value <= result[OUT_W-1];
                    shreg     <= result;
                    bitcnt    <= '0;
                    ow        <= ow + 1'b1;
                end else if (bitcnt == BW'(OUT_W - 1) && ow == last_ow) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_value <= 1'b0;
                end else begin
                    out_value <= shreg[OUT_W-2];
                    shreg     <= shreg << 1;
                    bitcnt    <= bitcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tmpl_xcorr.sv
// tb_tmpl_xcorr: directed scenarios for tmpl_xcorr on a 16-max and an 8-max instance.
module tb_tmpl_xcorr;

    localparam int OW = 20;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       iv_a = 1'b0, iv2_a = 1'b0, iv_b = 1'b0, iv2_b = 1'b0;
    logic [7:0] img_a = '0, tpl_a = '0, img_b = '0, tpl_b = '0;
    logic [1:0] sz_a = '0, act_a = '0, sz_b = '0, act_b = '0;
    logic       ov_a, val_a, ov_b, val_b;

    int pass_cnt = 0, total = 0;
    int img [256];
    int tpl [9];
    int res [256];
    int nbits, lat;

    always #5 clk = ~clk;

    tmpl_xcorr dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_valid2(iv2_a),
        .image(img_a), .template(tpl_a), .image_size(sz_a), .action(act_a),
        .out_valid(ov_a), .out_value(val_a)
    );

    tmpl_xcorr #(.MAX_SIZE(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_valid2(iv2_b),
        .image(img_b), .template(tpl_b), .image_size(sz_b), .action(act_b),
        .out_valid(ov_b), .out_value(val_b)
    );

    function automatic logic ov_of(input bit b);
        return b ? ov_b : ov_a;
    endfunction

    function automatic logic val_of(input bit b);
        return b ? val_b : val_a;
    endfunction

    function automatic int nbr(input int n, input int idx);
        int r, c;
        r = idx / n;
        c = idx % n;
        return ((r == 0 || r == n - 1) ? 2 : 3) * ((c == 0 || c == n - 1) ? 2 : 3);
    endfunction

    task automatic load(input bit b, input int n, input logic [1:0] sz);
        for (int k = 0; k < n * n; k++) begin
            @(negedge clk);
            if (b) begin
                iv_b = 1'b1; img_b = 8'(img[k]); tpl_b = k < 9 ? 8'(tpl[k]) : 8'd0; sz_b = sz;
            end else begin
                iv_a = 1'b1; img_a = 8'(img[k]); tpl_a = k < 9 ? 8'(tpl[k]) : 8'd0; sz_a = sz;
            end
        end
        @(negedge clk);
        iv_a = 1'b0;
        iv_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic act(input bit b, input logic [1:0] a);
        if (b) begin iv2_b = 1'b1; act_b = a; end
        else begin iv2_a = 1'b1; act_a = a; end
        @(negedge clk);
        iv2_a = 1'b0;
        iv2_b = 1'b0;
    endtask

    task automatic capture(input bit b);
        for (int i = 0; i < 256; i++) res[i] = 0;
        nbits = 0;
        lat = 1;
        while (!ov_of(b) && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        while (ov_of(b) && nbits < 6000) begin
            if (nbits / OW < 256) res[nbits / OW] = (res[nbits / OW] << 1) | int'(val_of(b));
            nbits++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({ov_a, val_a, ov_b, val_b} !== 4'b0) $display("FAIL reset_outputs: got %b want 0000", {ov_a, val_a, ov_b, val_b});
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        act(1'b0, 2'd0);
        capture(1'b0);
        total++;
        if (nbits !== 0) $display("FAIL unloaded_action: got %0d output cycles want 0", nbits);
        else pass_cnt++;
    endtask

    task automatic test_ones;
        for (int k = 0; k < 256; k++) img[k] = 1;
        for (int k = 0; k < 9; k++) tpl[k] = 1;
        load(1'b0, 4, 2'd0);
        act(1'b0, 2'd0);
        capture(1'b0);
        total++;
        if (lat !== 11) $display("FAIL ones_latency: got %0d want 11", lat); else pass_cnt++;
        total++;
        if (nbits !== 320) $display("FAIL ones_length: got %0d want 320", nbits); else pass_cnt++;
        total++;
        if (val_a !== 1'b0) $display("FAIL ones_idle_value: got %b want 0", val_a); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (res[i] !== nbr(4, i)) $display("FAIL ones_res%0d: got %0d want %0d", i, res[i], nbr(4, i));
            else pass_cnt++;
        end
    endtask

    task automatic test_negate;
        act(1'b0, 2'd2);
        capture(1'b0);
        total++;
        if (nbits !== 320) $display("FAIL neg_length: got %0d want 320", nbits); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (res[i] !== nbr(4, i) * 254) $display("FAIL neg_res%0d: got %0d want %0d", i, res[i], nbr(4, i) * 254);
            else pass_cnt++;
        end
    endtask

    task automatic test_flip;
        for (int k = 0; k < 256; k++) img[k] = 0;
        for (int k = 0; k < 9; k++) tpl[k] = 0;
        img[0] = 1;
        tpl[4] = 1;
        load(1'b0, 4, 2'd0);
        act(1'b0, 2'd1);
        capture(1'b0);
        for (int i = 0; i < 16; i++) begin
            total++;
            if (res[i] !== (i == 3 ? 1 : 0)) $display("FAIL flip_res%0d: got %0d want %0d", i, res[i], i == 3 ? 1 : 0);
            else pass_cnt++;
        end
    endtask

    task automatic test_big;
        for (int k = 0; k < 256; k++) img[k] = 255;
        for (int k = 0; k < 9; k++) tpl[k] = 255;
        load(1'b0, 16, 2'd2);
        act(1'b0, 2'd0);
        capture(1'b0);
        total++;
        if (nbits !== 5120) $display("FAIL big_length: got %0d want 5120", nbits); else pass_cnt++;
        total++;
        if (res[0] !== 260100) $display("FAIL big_corner: got %0d want 260100", res[0]); else pass_cnt++;
        total++;
        if (res[1] !== 390150) $display("FAIL big_top_edge: got %0d want 390150", res[1]); else pass_cnt++;
        total++;
        if (res[16] !== 390150) $display("FAIL big_left_edge: got %0d want 390150", res[16]); else pass_cnt++;
        total++;
        if (res[17] !== 585225) $display("FAIL big_interior: got %0d want 585225", res[17]); else pass_cnt++;
        total++;
        if (res[255] !== 260100) $display("FAIL big_last: got %0d want 260100", res[255]); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int nz;
        act(1'b0, 2'd3);
        capture(1'b0);
        nz = 0;
        for (int i = 0; i < 256; i++) if (res[i] != 0) nz++;
        total++;
        if (lat !== 11) $display("FAIL b2b_latency: got %0d want 11", lat); else pass_cnt++;
        total++;
        if (nbits !== 5120) $display("FAIL b2b_length: got %0d want 5120", nbits); else pass_cnt++;
        total++;
        if (nz !== 0) $display("FAIL b2b_nonzero: got %0d nonzero results want 0", nz); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        act(1'b0, 2'd0);
        capture(1'b0);
        act(1'b0, 2'd0);
        lat = 0;
        while (!ov_a && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        repeat (50) @(negedge clk);
        total++;
        if (ov_a !== 1'b1) $display("FAIL mid_active: got %b want 1", ov_a); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({ov_a, val_a} !== 2'b00) $display("FAIL mid_reset_outputs: got %b want 00", {ov_a, val_a});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        act(1'b0, 2'd0);
        capture(1'b0);
        total++;
        if (nbits !== 0) $display("FAIL mid_no_reload: got %0d output cycles want 0", nbits); else pass_cnt++;
    endtask

    task automatic test_size_clamp;
        for (int k = 0; k < 256; k++) img[k] = 1;
        for (int k = 0; k < 9; k++) tpl[k] = 1;
        load(1'b1, 8, 2'd2);
        act(1'b1, 2'd0);
        capture(1'b1);
        total++;
        if (lat !== 11) $display("FAIL clamp_latency: got %0d want 11", lat); else pass_cnt++;
        total++;
        if (nbits !== 1280) $display("FAIL clamp_length: got %0d want 1280", nbits); else pass_cnt++;
        total++;
        if (res[0] !== 4) $display("FAIL clamp_corner: got %0d want 4", res[0]); else pass_cnt++;
        total++;
        if (res[1] !== 6) $display("FAIL clamp_edge: got %0d want 6", res[1]); else pass_cnt++;
        total++;
        if (res[7] !== 4) $display("FAIL clamp_right_corner: got %0d want 4", res[7]); else pass_cnt++;
        total++;
        if (res[9] !== 9) $display("FAIL clamp_interior: got %0d want 9", res[9]); else pass_cnt++;
        total++;
        if (res[63] !== 4) $display("FAIL clamp_last: got %0d want 4", res[63]); else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_ones;
        test_negate;
        test_flip;
        test_big;
        test_back_to_back;
        test_reset_mid;
        test_size_clamp;
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
